// File: rtl/fir_seq_pkg.sv
// Shared definitions for the FIR multiply-accumulate sequencer: FSM states,
// vector ALU opcodes and default vector geometry.
package fir_seq_pkg;

  localparam int DEFAULT_LANES  = 16;
  localparam int DEFAULT_LANE_W = 16;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_MUL = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_X,
    S_FETCH_H,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  // Tap counts above the vector depth saturate at 16
  function automatic logic [4:0] clamp_taps(input logic [4:0] n);
    return (n > 5'd16) ? 5'd16 : n;
  endfunction

endpackage

// File: rtl/fir_mac_sequencer.sv
// Sequences a FIR dot product over vector lanes: fetches sample and coefficient
// vectors from memory, multiplies and accumulates them through an external ALU.
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int LANE_W = DEFAULT_LANE_W,
  parameter int AW     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4:0]              num_taps,
  input  logic [AW-1:0]           x_base,
  input  logic [AW-1:0]           h_base,
  output logic                    rd_req,
  output logic [AW-1:0]           rd_addr,
  input  logic [LANES*LANE_W-1:0] rd_data,
  input  logic                    rd_valid,
  output logic [LANES*LANE_W-1:0] alu_a,
  output logic [LANES*LANE_W-1:0] alu_b,
  output logic [2:0]              alu_ctrl,
  output logic                    alu_vec_sel,
  input  logic [LANES*LANE_W-1:0] alu_result,
  output logic                    busy,
  output logic                    done,
  output logic [LANES*LANE_W-1:0] result
);

  localparam int VW = LANES * LANE_W;

  state_t          state, state_nxt;
  logic [4:0]      ntaps;
  logic [4:0]      k;
  logic [AW-1:0]   xb, hb;
  logic [VW-1:0]   xreg, hreg, preg, acc;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Datapath captures are suppressed on abort so a cancelled run leaves no trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ntaps  <= '0;
      k      <= '0;
      xb     <= '0;
      hb     <= '0;
      xreg   <= '0;
      hreg   <= '0;
      preg   <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              ntaps <= clamp_taps(num_taps);
              xb    <= x_base;
              hb    <= h_base;
              acc   <= '0;
              k     <= '0;
            end
          end
          S_FETCH_X: if (rd_valid) xreg <= rd_data;
          S_FETCH_H: if (rd_valid) hreg <= rd_data;
          S_MUL:     preg <= alu_result;
          S_ACC: begin
            acc <= alu_result;
            k   <= k + 5'd1;
          end
          S_DONE:    result <= acc;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_req      = 1'b0;
    rd_addr     = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = ALU_OP_ADD;
    alu_vec_sel = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (clamp_taps(num_taps) == 5'd0) ? S_DONE : S_FETCH_X;
      end
      S_FETCH_X: begin
        rd_req  = 1'b1;
        rd_addr = xb + AW'(k);
        if (rd_valid) state_nxt = S_FETCH_H;
      end
      S_FETCH_H: begin
        rd_req  = 1'b1;
        rd_addr = hb + AW'(k);
        if (rd_valid) state_nxt = S_MUL;
      end
      S_MUL: begin
        alu_ctrl    = ALU_OP_MUL;
        alu_vec_sel = 1'b1;
        alu_a       = xreg;
        alu_b       = hreg;
        state_nxt   = S_ACC;
      end
      S_ACC: begin
        alu_ctrl    = ALU_OP_ADD;
        alu_vec_sel = 1'b1;
        alu_a       = acc;
        alu_b       = preg;
        state_nxt   = ((k + 5'd1) == ntaps) ? S_DONE : S_FETCH_X;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort outranks every other transition, including start in IDLE
    if (abort) state_nxt = S_IDLE;
  end

endmodule
